jtpopeye_sdram_arb: RTL and testbench
=====================================

Name: jtpopeye_sdram_arb

Overview:
- Shares the single SDRAM read port between three ROM requesters.
  - 0: main CPU ROM.
  - 1: character ROM.
  - 2: object ROM.
- Sits in the game top level, on the 40 MHz game clock domain, next to the PLL that provides clk and the phase-shifted SDRAM clock.
- Grants are round-robin.
- No grant is issued until the PLL lock indication has been stable.

Parameters:
- AW, 22, word address width of every requester and of the SDRAM port.
- DW, 16, data width.
- LOCK_CNT, 4, consecutive clk cycles pll_locked must be high before the first grant.

Ports:
- clk  in  1  game clock, 40 MHz from the PLL.
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL lock; synchronised internally with 2 flops.
- req  in  3  per-requester read request; level, held until ok.
- addr  in  3*AW  requester i uses bits [i*AW +: AW].
- ok  out  3  per-requester data valid; level.
- dout  out  3*DW  per-requester data, held until next service of that requester.
- sdram_req  out  1  request to the SDRAM controller.
- sdram_addr  out  AW  address of the granted request.
- sdram_ack  in  1  controller accepted the request (1-cycle pulse).
- sdram_rdy  in  1  read data valid (1-cycle pulse).
- sdram_din  in  DW  read data.

Behaviour:
- Reset values (async on rst): ok=0, dout=0, sdram_req=0, sdram_addr=0, state=LOCK, rr pointer=2 (so requester 0 wins first), lock counter=0.
- Lock counter: counts up while synced lock=1 and clears when it is 0. The ready flag sets at LOCK_CNT and drops immediately when lock is lost.
- LOCK: go to IDLE when ready=1.
- IDLE: a requester is pending when req[i]=1 and ok[i]=0.
  - If ready=0: go to LOCK and issue no grant.
  - Otherwise pick the first pending requester scanning rr+1, rr+2, rr+3 (mod 3).
  - Latch its index g and addr. Next cycle sdram_req=1, sdram_addr=latched addr, state=WAIT_ACK. Set rr=g.
  - If nothing is pending, stay in IDLE.
- WAIT_ACK: hold sdram_req and sdram_addr until sdram_ack=1. Then sdram_req=0 on the next edge and state=WAIT_RDY.
- WAIT_RDY: on sdram_rdy, latch sdram_din into dout[g] and go to IDLE.
  - If addr[g] still equals the latched address, set ok[g]=1 in the same edge. Data is therefore visible one cycle after rdy.
  - Otherwise ok[g] stays 0 and the requester is served again later.
- Latency: req sampled in IDLE at cycle n gives sdram_req at n+1. There is one IDLE cycle between back-to-back grants.
- ok[i] clears on the edge after req[i]=0 or after addr[i] differs from the address that produced ok[i]. A per-requester address register holds that address.
- Simultaneous set and clear: if addr[g] changes on the rdy cycle, set is not applied (see the WAIT_RDY rule).
- Lock loss mid-transaction: the current transaction completes (SDRAM still clocked), then the FSM goes to LOCK.
- Stray sdram_ack in IDLE or WAIT_RDY and stray sdram_rdy outside WAIT_RDY are ignored.
- Reset mid-transaction: everything returns to reset values immediately. An in-flight SDRAM reply is dropped.

Optional Feature:
- Macro: JTPOPEYE_ARB_CACHE_EN.
- Defined:
  - Each requester keeps a one-entry cache: tag of AW bits plus a valid bit. Valid is set when dout is latched.
  - When req[i]=1, ok[i]=0 and addr[i] equals a valid tag, ok[i] sets on the next edge without an SDRAM access. This happens in any state and is not counted as a grant.
  - Cache valid bits clear on rst.
- Undefined: every ok requires an SDRAM transaction, and no tag storage is generated.

Decomposition:
- Package jtpopeye_arb_pkg contains:
  - state enum {LOCK, IDLE, WAIT_ACK, WAIT_RDY};
  - NREQ=3 constant;
  - requester index constants CPU=0, CHR=1, OBJ=2.
- One sub-module, jtpopeye_arb_rr: a combinational round-robin picker taking pending[2:0] and rr[1:0] and returning valid and g[1:0]. It is reused by the scroll-ROM arbiter.

Test Plan:
- Lock gating: pll_locked=0 with req=3'b111 → no sdram_req. Raise lock → first sdram_req exactly 2+LOCK_CNT+2 cycles later, with sdram_addr=addr0.
- Round-robin: req=111 with a controller model giving ack at +2 and rdy at +5 → grant order 0,1,2,0. ok[g] rises one cycle after each rdy; dout[g]=model data (addr XOR 16'h5A5A).
- Address change: requester 1 changes addr 0x000100→0x000200 during WAIT_RDY → ok[1] stays 0, and a second SDRAM access goes to 0x000200.
- ok clear: after ok[0]=1, drop req[0] → ok[0]=0 next cycle. A new addr with req high → new access.
- Reset mid-transaction: assert rst in WAIT_RDY → sdram_req=0 and ok=0 immediately. A late sdram_rdy is ignored and dout stays 0.
- Cache (macro on): re-request addr 0x000010 already served to requester 2 → ok[2]=1 in 1 cycle with zero sdram_req pulses.

Source files
------------

// File: rtl/jtpopeye_arb_pkg.sv
// -----------------------------------------------------------------------------
// jtpopeye_arb_pkg
// Shared definitions for the Popeye SDRAM ROM arbiters.
//   NREQ           number of ROM requesters sharing the SDRAM read port
//   CPU, CHR, OBJ  requester indices (main CPU ROM, character ROM, object ROM)
//   arb_state_t    arbiter FSM states
//   wrap3()        reduces a small sum modulo 3 (round-robin index arithmetic)
// -----------------------------------------------------------------------------
package jtpopeye_arb_pkg;

    localparam int NREQ = 3;

    localparam logic [1:0] CPU = 2'd0;
    localparam logic [1:0] CHR = 2'd1;
    localparam logic [1:0] OBJ = 2'd2;

    typedef enum logic [1:0] {
        LOCK     = 2'd0,
        IDLE     = 2'd1,
        WAIT_ACK = 2'd2,
        WAIT_RDY = 2'd3
    } arb_state_t;

    // Operand range is 0..6 (rr 0..3 plus offset 1..3), so two subtractions
    // cover it without a divider.
    function automatic logic [1:0] wrap3(input logic [2:0] v);
        logic [2:0] r;
        if (v >= 3'd6)      r = v - 3'd6;
        else if (v >= 3'd3) r = v - 3'd3;
        else                r = v;
        return r[1:0];
    endfunction

endpackage

// File: rtl/jtpopeye_arb_rr.sv
// -----------------------------------------------------------------------------
// jtpopeye_arb_rr
// Combinational round-robin picker over three requesters. Scans rr+1, rr+2,
// rr+3 (mod 3) and returns the first pending index.
//   pending  in  3  requesters currently wanting service
//   rr       in  2  index granted last time
//   valid    out 1  at least one requester is pending
//   g        out 2  selected requester (meaningful only when valid=1)
// -----------------------------------------------------------------------------
module jtpopeye_arb_rr
    import jtpopeye_arb_pkg::*;
(
    input  logic [2:0] pending,
    input  logic [1:0] rr,
    output logic       valid,
    output logic [1:0] g
);

    logic [1:0] cand;

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        valid = 1'b0;
        g     = CPU;
        cand  = CPU;
        // Scanning from the farthest candidate back lets the nearest pending
        // one overwrite the result, giving first-match priority.
        for (int k = 3; k >= 1; k--) begin
            cand = wrap3({1'b0, rr} + 3'(k));
            if (pending[cand]) begin
                valid = 1'b1;
                g     = cand;
            end
        end
    end

endmodule

// File: rtl/jtpopeye_sdram_arb.sv
// -----------------------------------------------------------------------------
// jtpopeye_sdram_arb
// Shares the single SDRAM read port between the CPU, character and object ROM
// requesters with round-robin grants. No grant is issued until the PLL lock
// has been stable for LOCK_CNT cycles after a 2-flop synchroniser.
//
// Optional feature (macro JTPOPEYE_ARB_CACHE_EN): each requester keeps a
// one-entry tag cache so a re-request of the last served address completes
// in one cycle without an SDRAM access.
//
// Ports:
//   clk         in   1       40 MHz game clock
//   rst         in   1       asynchronous, active-high reset
//   pll_locked  in   1       PLL lock (asynchronous)
//   req         in   3       per-requester read request, held until ok
//   addr        in   3*AW    requester i address at [i*AW +: AW]
//   ok          out  3       per-requester data valid (level)
//   dout        out  3*DW    per-requester data, held until next service
//   sdram_req   out  1       request to the SDRAM controller
//   sdram_addr  out  AW      address of the granted request
//   sdram_ack   in   1       controller accepted the request (pulse)
//   sdram_rdy   in   1       read data valid (pulse)
//   sdram_din   in   DW      read data
// -----------------------------------------------------------------------------
module jtpopeye_sdram_arb
    import jtpopeye_arb_pkg::*;
#(
    parameter int AW       = 22,
    parameter int DW       = 16,
    parameter int LOCK_CNT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pll_locked,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   addr,
    output logic [NREQ-1:0]      ok,
    output logic [NREQ*DW-1:0]   dout,
    output logic                 sdram_req,
    output logic [AW-1:0]        sdram_addr,
    input  logic                 sdram_ack,
    input  logic                 sdram_rdy,
    input  logic [DW-1:0]        sdram_din
);

    localparam int CW = $clog2(LOCK_CNT + 1);

    logic                      lock_s1, lock_s2;
    logic [CW-1:0]             lock_cnt;
    logic                      ready;

    arb_state_t                state;
    logic [1:0]                rr, g;
    logic [NREQ-1:0][AW-1:0]   a;
    logic [NREQ-1:0][AW-1:0]   ok_addr;
    logic [NREQ-1:0]           hit, hit_set, pending;
    logic                      pick_valid;
    logic [1:0]                pick;
    logic                      dout_we;

    assign a       = addr;
    assign dout_we = (state == WAIT_RDY) && sdram_rdy;

    // Lock qualification: ready is combinational so it drops in the same
    // cycle the synchronised lock falls.
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples values from before the edge regardless of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_s1  <= 1'b0;
            lock_s2  <= 1'b0;
            lock_cnt <= '0;
        end else begin
            lock_s1 <= pll_locked;
            lock_s2 <= lock_s1;
            if (!lock_s2)
                lock_cnt <= '0;
            else if (lock_cnt != CW'(LOCK_CNT))
                lock_cnt <= lock_cnt + 1'b1;
        end
    end

    assign ready = lock_s2 && (lock_cnt == CW'(LOCK_CNT));

`ifdef JTPOPEYE_ARB_CACHE_EN
    logic [NREQ-1:0][AW-1:0] tag;
    logic [NREQ-1:0]         tag_v;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NREQ; i++)
            hit[i] = tag_v[i] && (a[i] == tag[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tag_v <= '0;
        else if (dout_we)
            tag_v[g] <= 1'b1;
    end

    // NOTE: tag storage has no reset; the valid bits alone decide whether a
    // tag is meaningful, so clearing the storage would buy nothing.
    always_ff @(posedge clk) begin
        if (dout_we)
            tag[g] <= sdram_addr;
    end
`else
    assign hit = '0;
`endif

    // A cache hit completes locally, so it is never offered to the picker.
    assign hit_set = req & ~ok & hit;
    assign pending = req & ~ok & ~hit;

    jtpopeye_arb_rr u_rr (
        .pending (pending),
        .rr      (rr),
        .valid   (pick_valid),
        .g       (pick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LOCK;
            rr         <= OBJ;
            g          <= CPU;
            ok         <= '0;
            ok_addr    <= '0;
            dout       <= '0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
        end else begin
            // ok tracks the address it was produced for; a dropped request or
            // a moved address invalidates it on the next edge.
            for (int i = 0; i < NREQ; i++) begin
                if (ok[i] && (!req[i] || a[i] != ok_addr[i]))
                    ok[i] <= 1'b0;
                if (hit_set[i]) begin
                    ok[i]      <= 1'b1;
                    ok_addr[i] <= a[i];
                end
            end

            case (state)
                LOCK: begin
                    if (ready)
                        state <= IDLE;
                end
                IDLE: begin
                    if (!ready)
                        state <= LOCK;
                    else if (pick_valid) begin
                        g          <= pick;
                        rr         <= pick;
                        sdram_addr <= a[pick];
                        sdram_req  <= 1'b1;
                        state      <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        state     <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    // Lock loss is not checked here: the SDRAM is still
                    // clocked, so the reply is taken and IDLE falls to LOCK.
                    if (sdram_rdy) begin
                        dout[g*DW +: DW] <= sdram_din;
                        // A requester that moved on during the access keeps
                        // ok low and is picked again for its new address.
                        if (a[g] == sdram_addr) begin
                            ok[g]      <= 1'b1;
                            ok_addr[g] <= sdram_addr;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= LOCK;
            endcase
        end
    end

endmodule

// File: tb/tb_jtpopeye_sdram_arb.sv
// -----------------------------------------------------------------------------
// tb_jtpopeye_sdram_arb
// Scoreboard bench: stimulus pushes expected SDRAM addresses and expected
// (requester, data) completions; a negedge monitor pops and compares on every
// sdram_req rise and every ok[i] rise. A controller model answers each
// request with ack two cycles and rdy five cycles after sdram_req rises,
// returning addr[15:0] ^ 16'h5A5A.
// -----------------------------------------------------------------------------
module tb_jtpopeye_sdram_arb;

    localparam int AW       = 22;
    localparam int DW       = 16;
    localparam int LOCK_CNT = 4;

    typedef struct {
        int          idx;
        logic [15:0] data;
    } ok_exp_t;

    logic              clk;
    logic              rst;
    logic              pll_locked;
    logic [2:0]        req;
    logic [AW-1:0]     a0, a1, a2;
    logic [3*AW-1:0]   addr;
    logic [2:0]        ok;
    logic [3*DW-1:0]   dout;
    logic              sdram_req;
    logic [AW-1:0]     sdram_addr;
    logic              sdram_ack;
    logic              sdram_rdy;
    logic [DW-1:0]     sdram_din;

    assign addr = {a2, a1, a0};

    jtpopeye_sdram_arb #(.AW(AW), .DW(DW), .LOCK_CNT(LOCK_CNT)) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .req        (req),
        .addr       (addr),
        .ok         (ok),
        .dout       (dout),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .sdram_rdy  (sdram_rdy),
        .sdram_din  (sdram_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [AW-1:0] exp_grant[$];
    ok_exp_t       exp_ok[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic logic [15:0] model_data(input logic [AW-1:0] ad);
        return ad[15:0] ^ 16'h5A5A;
    endfunction

    task automatic expect_grant(input logic [AW-1:0] ad);
        exp_grant.push_back(ad);
    endtask

    task automatic expect_ok(input int idx, input logic [AW-1:0] ad);
        ok_exp_t e;
        e.idx  = idx;
        e.data = model_data(ad);
        exp_ok.push_back(e);
    endtask

    // ---------------- SDRAM controller model ----------------
    bit            model_en = 1'b1;
    logic [AW-1:0] model_addr;

    initial begin : ctrl_model
        forever begin
            @(negedge clk);
            if (model_en && sdram_req) begin
                model_addr = sdram_addr;
                @(posedge clk); #1 sdram_ack = 1'b1;
                @(posedge clk); #1 sdram_ack = 1'b0;
                repeat (2) @(posedge clk);
                #1 sdram_rdy = 1'b1;
                sdram_din = model_data(model_addr);
                @(posedge clk); #1 sdram_rdy = 1'b0;
            end
        end
    end

    // ---------------- Monitor ----------------
    logic          mon_req_prev = 1'b0;
    logic [2:0]    mon_ok_prev  = 3'b000;
    logic [AW-1:0] mon_ga;
    ok_exp_t       mon_oe;

    always @(negedge clk) begin
        if (sdram_req && !mon_req_prev) begin
            if (exp_grant.size() == 0)
                fail_now("unexpected_grant");
            else begin
                mon_ga = exp_grant.pop_front();
                check("grant_addr", 64'(sdram_addr), 64'(mon_ga));
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (ok[i] && !mon_ok_prev[i]) begin
                if (exp_ok.size() == 0)
                    fail_now("unexpected_ok");
                else begin
                    mon_oe = exp_ok.pop_front();
                    check("ok_idx", 64'(i), 64'(mon_oe.idx));
                    check("ok_data", 64'(dout[i*DW +: DW]), 64'(mon_oe.data));
                end
            end
        end
        mon_req_prev = sdram_req;
        mon_ok_prev  = ok;
    end

    // ---------------- Helpers ----------------
    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_grant.size() != 0 || exp_ok.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_grant.size() != 0 || exp_ok.size() != 0)
            fail_now("drain_timeout");
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_ok(input int idx, input int budget);
        int n = 0;
        @(negedge clk);
        while (!ok[idx] && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!ok[idx]) fail_now("wait_ok_timeout");
    endtask

    task automatic wait_sdram_req(input logic level, input int budget);
        int n = 0;
        @(negedge clk);
        while (sdram_req !== level && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sdram_req !== level) fail_now("wait_sdram_req_timeout");
    endtask

    // ---------------- Stimulus ----------------
    initial begin : stim
        int lat;

        rst        = 1'b1;
        pll_locked = 1'b0;
        req        = 3'b000;
        a0         = '0;
        a1         = '0;
        a2         = '0;
        sdram_ack  = 1'b0;
        sdram_rdy  = 1'b0;
        sdram_din  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ok", 64'(ok), 64'(0));
        check("rst_dout", 64'(dout), 64'(0));
        check("rst_sdram_req", 64'(sdram_req), 64'(0));
        check("rst_sdram_addr", 64'(sdram_addr), 64'(0));
        rst = 1'b0;

        // Lock gating, then round-robin 0,1,2,0.
        a0  = 22'h001234;
        a1  = 22'h000180;
        a2  = 22'h000010;
        req = 3'b111;
        repeat (20) @(posedge clk);
        #1;
        check("no_grant_unlocked", 64'(sdram_req), 64'(0));

        expect_grant(22'h001234); expect_ok(0, 22'h001234);
        expect_grant(22'h000180); expect_ok(1, 22'h000180);
        expect_grant(22'h000010); expect_ok(2, 22'h000010);

        pll_locked = 1'b1;
        lat = 0;
        while (!sdram_req && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("lock_latency", 64'(lat), 64'(2 + LOCK_CNT + 2));
        check("first_addr", 64'(sdram_addr), 64'(22'h001234));

        // Requester 0 moves on while 1 is being served: it must come after 2.
        wait_ok(0, 40);
        a0 = 22'h001238;
        expect_grant(22'h001238); expect_ok(0, 22'h001238);
        @(posedge clk);
        #1;
        check("ok0_clear_on_addr", 64'(ok[0]), 64'(0));
        wait_drain(200);

        // Dropping req clears ok on the next edge; a new address is fetched.
        @(posedge clk);
        #1 req[0] = 1'b0;
        @(posedge clk);
        #1;
        check("ok0_clear_on_req", 64'(ok[0]), 64'(0));
        a0     = 22'h002000;
        req[0] = 1'b1;
        expect_grant(22'h002000); expect_ok(0, 22'h002000);
        wait_drain(100);

        // Address change during WAIT_RDY: no ok for the stale address.
        a1 = 22'h000100;
        expect_grant(22'h000100);
        wait_sdram_req(1'b1, 40);
        wait_sdram_req(1'b0, 40);
        a1 = 22'h000200;
        expect_grant(22'h000200); expect_ok(1, 22'h000200);
        wait_drain(100);
        check("ok_after_addr_change", 64'(ok), 64'(3'b111));

        // Re-request of the address requester 2 already holds.
        @(posedge clk);
        #1 req[2] = 1'b0;
        @(posedge clk);
        #1;
        check("ok2_clear_on_req", 64'(ok[2]), 64'(0));
        req[2] = 1'b1;
        expect_ok(2, 22'h000010);
`ifdef JTPOPEYE_ARB_CACHE_EN
        @(posedge clk);
        #1;
        check("cache_hit_1cycle", 64'(ok[2]), 64'(1));
        check("cache_no_sdram_req", 64'(sdram_req), 64'(0));
`else
        expect_grant(22'h000010);
`endif
        wait_drain(100);

        // Reset in WAIT_RDY: the late reply must be dropped.
        model_en = 1'b0;
        a0 = 22'h003000;
        expect_grant(22'h003000);
        wait_sdram_req(1'b1, 40);
        sdram_ack = 1'b1;
        @(posedge clk);
        #1 sdram_ack = 1'b0;
        rst = 1'b1;
        req = 3'b000;
        #1;
        check("midrst_sdram_req", 64'(sdram_req), 64'(0));
        check("midrst_ok", 64'(ok), 64'(0));
        check("midrst_dout", 64'(dout), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sdram_rdy = 1'b1;
        sdram_din = 16'hBEEF;
        @(posedge clk);
        #1 sdram_rdy = 1'b0;
        @(posedge clk);
        #1;
        check("late_rdy_dout", 64'(dout), 64'(0));
        check("late_rdy_ok", 64'(ok), 64'(0));
        repeat (15) @(posedge clk);
        #1;
        check("idle_after_reset", 64'(sdram_req), 64'(0));

        check("scoreboard_empty", 64'(exp_grant.size() + exp_ok.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog_timeout (t=%0t)", $time);
        $fatal(1, "simulation did not finish");
    end

endmodule
